// File: rtl/bridge_pkg.sv
// Shared constants for the sram-to-AXI3 bridge: FSM state codes, AXI size codes,
// fixed AXI attribute fields and default transaction IDs.
package bridge_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW   = 3'd3;
  localparam logic [2:0] ST_W    = 3'd4;
  localparam logic [2:0] ST_B    = 3'd5;
  localparam logic [2:0] ST_AW_W = 3'd6;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  localparam logic [3:0] AXI_LEN0        = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE       = 4'b0000;
  localparam logic [2:0] AXI_PROT        = 3'b000;

  localparam int INST_ID_DEF = 0;
  localparam int DATA_ID_DEF = 1;

  // The cache never issues size 3, but if it does, treat it as a full word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? AXI_SIZE_WORD : {1'b0, size};
  endfunction

endpackage

// File: rtl/wstrb_gen.sv
// Byte-lane strobe generator: turns an sram-style size and the low address bits
// into the AXI write strobe for a single 32-bit beat.
module wstrb_gen (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      2'd0:    wstrb = 4'b0001 << addr_lo;
      2'd1:    wstrb = 4'b0011 << addr_lo;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Converts the cache's inst/data sram-like ports into single-beat AXI3 accesses,
// one in flight at a time, data before inst. Define BRIDGE_AW_W_PARALLEL_EN to
// raise awvalid and wvalid together instead of sequencing W after AW.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int INST_ID  = INST_ID_DEF,
  parameter int DATA_ID  = DATA_ID_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  output logic [31:0]         inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic [31:0]         data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [AXI_ID_W-1:0] INST_AXI_ID = AXI_ID_W'(INST_ID);
  localparam logic [AXI_ID_W-1:0] DATA_AXI_ID = AXI_ID_W'(DATA_ID);
`ifdef BRIDGE_AW_W_PARALLEL_EN
  localparam logic [2:0] WR_START = ST_AW_W;
`else
  localparam logic [2:0] WR_START = ST_AW;
`endif

  logic [2:0]  state;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        req_src_data;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  strobe;
  logic        unused_inputs;
`ifdef BRIDGE_AW_W_PARALLEL_EN
  logic        aw_done;
  logic        w_done;
`endif

  assign data_addr_ok = (state == ST_IDLE) & data_req;
  assign inst_addr_ok = (state == ST_IDLE) & inst_req & ~data_req;

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = inst_size;
    sel_addr  = inst_addr;
    sel_wdata = 32'd0;
    if (data_req) begin
      sel_wr    = data_wr;
      sel_size  = data_size;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
    end
  end

  wstrb_gen u_wstrb_gen (
    .size    (req_size),
    .addr_lo (req_addr[1:0]),
    .wstrb   (strobe)
  );

  // Valids are decoded straight from the state register, so they cannot glitch
  // and stay high until the state advances on the matching ready.
  assign arvalid = (state == ST_AR);
  assign rready  = (state == ST_R);
  assign bready  = (state == ST_B);
`ifdef BRIDGE_AW_W_PARALLEL_EN
  assign awvalid = (state == ST_AW_W) & ~aw_done;
  assign wvalid  = (state == ST_AW_W) & ~w_done;
`else
  assign awvalid = (state == ST_AW);
  assign wvalid  = (state == ST_W);
`endif
  assign wlast   = wvalid;
  assign wstrb   = wvalid ? strobe : 4'b0000;
  assign wdata   = req_wdata;

  assign arid    = req_src_data ? DATA_AXI_ID : INST_AXI_ID;
  assign awid    = arid;
  assign araddr  = req_addr;
  assign awaddr  = req_addr;
  assign arsize  = axi_size(req_size);
  assign awsize  = arsize;
  assign arlen   = AXI_LEN0;
  assign awlen   = AXI_LEN0;
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign awlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE;
  assign awcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awprot  = AXI_PROT;

  // Responses, IDs and last flags carry no information with one access in flight.
  assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bresp};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_addr     <= 32'd0;
      req_size     <= 2'd0;
      req_wdata    <= 32'd0;
      req_src_data <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
`ifdef BRIDGE_AW_W_PARALLEL_EN
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
`endif
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (data_req || inst_req) begin
            req_addr     <= sel_addr;
            req_size     <= sel_size;
            req_wdata    <= sel_wdata;
            req_src_data <= data_req;
            state        <= sel_wr ? WR_START : ST_AR;
          end
        end
        ST_AR: if (arready) state <= ST_R;
        ST_R: begin
          if (rvalid) begin
            if (req_src_data) begin
              data_rdata   <= rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= rdata;
              inst_data_ok <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        ST_AW: if (awready) state <= ST_W;
        ST_W:  if (wready) state <= ST_B;
        ST_B: begin
          if (bvalid) begin
            data_data_ok <= 1'b1;
            state        <= ST_IDLE;
          end
        end
`ifdef BRIDGE_AW_W_PARALLEL_EN
        // Each channel retires on its own handshake; leave once both are done.
        ST_AW_W: begin
          if ((aw_done || awready) && (w_done || wready)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_B;
          end else begin
            aw_done <= aw_done | awready;
            w_done  <= w_done | wready;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
